// File: rtl/icache_pkg.sv
// ============================================================================
//  icache_pkg
//  Shared types for the instruction cache: word type, frame layout,
//  address overlay and FSM state encoding.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

    localparam int c_word_w = 32;
    localparam int c_sets   = 16;
    localparam int c_idx_w  = $clog2(c_sets);
    localparam int c_tag_w  = 30 - c_idx_w;

    typedef logic [c_word_w-1:0] word_t;

    typedef struct packed {
        logic               valid;
        logic [c_tag_w-1:0] tag;
        word_t              data;
    } icache_frame_t;

    typedef struct packed {
        logic [c_tag_w-1:0] tag;
        logic [c_idx_w-1:0] idx;
        logic [1:0]         bytoff;
    } icachef_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
//  icache
//  Direct-mapped, read-only, one-word-per-frame instruction cache with a
//  single-outstanding-miss fill FSM. Optional ICACHE_STATS_EN adds counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module icache
    import icache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    icache_state_t    r_state;
    icache_state_t    w_next;
    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    word_t            r_data [SETS];
    logic [31:0]      r_miss_addr;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic             w_hit;
    logic             w_fill;
    logic             w_miss_start;
    logic             w_unused_bytoff;

    assign w_idx           = imemaddr[IDX_W+1:2];
    assign w_tag           = imemaddr[31:IDX_W+2];
    assign w_fill_idx      = r_miss_addr[IDX_W+1:2];
    assign w_fill_tag      = r_miss_addr[31:IDX_W+2];
    assign w_unused_bytoff = ^{imemaddr[1:0], r_miss_addr[1:0]};

    // Lookup is only meaningful while idle; a fill in flight always stalls.
    assign w_hit = (r_state == IDLE) && imemREN && r_valid[w_idx]
                   && (r_tag[w_idx] == w_tag);

    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_idx] : 32'h0;

    always_comb begin
        w_next       = r_state;
        iREN         = 1'b0;
        iaddr        = 32'h0;
        w_fill       = 1'b0;
        w_miss_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (imemREN && !w_hit) begin
                    w_miss_start = 1'b1;
                    w_next       = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = r_miss_addr;
                if (!iwait) begin
                    w_fill = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_miss_addr <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_miss_start) begin
                r_miss_addr <= {imemaddr[31:2], 2'b00};
            end
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data need no reset; gating on reset keeps an aborted fill from landing.
    always_ff @(posedge CLK) begin
        if (w_fill && !nRST) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (nRST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (w_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (w_miss_start) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
//  tb_icache
//  Directed, table-driven bench for icache; one record per clock cycle.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_icache;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    icache dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        ren;
        logic [31:0] addr;
        logic        wt;
        logic [31:0] ld;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_ren;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ren, input logic [31:0] addr,
                       input logic wt, input logic [31:0] ld,
                       input logic e_hit, input logic [31:0] e_load,
                       input logic e_ren, input logic [31:0] e_iaddr);
        vec_t v;
        v.rst = rst; v.ren = ren; v.addr = addr; v.wt = wt; v.ld = ld;
        v.e_hit = e_hit; v.e_load = e_load; v.e_ren = e_ren; v.e_iaddr = e_iaddr;
        vecs.push_back(v);
    endtask

    task automatic check32(input string name, input int cyc,
                           input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ren, input logic [31:0] addr,
                         input logic wt, input logic [31:0] ld);
        nRST = rst; imemREN = ren; imemaddr = addr; iwait = wt; iload = ld;
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);

        //   rst ren addr          wait load           hit  imemload       iREN iaddr
        add(1, 0, 32'h0000_0000, 1, 32'h0,           0, 32'h0,           0, 32'h0);
        add(1, 1, 32'h0000_0040, 1, 32'h0,           0, 32'h0,           0, 32'h0);
        // cold miss, memory busy three cycles
        add(0, 1, 32'h0000_0040, 1, 32'h0,           0, 32'h0,           0, 32'h0);
        add(0, 1, 32'h0000_0040, 1, 32'h0,           0, 32'h0,           1, 32'h40);
        add(0, 1, 32'h0000_0040, 1, 32'h0,           0, 32'h0,           1, 32'h40);
        add(0, 1, 32'h0000_0040, 1, 32'h0,           0, 32'h0,           1, 32'h40);
        add(0, 1, 32'h0000_0040, 0, 32'h2001_0005,   0, 32'h0,           1, 32'h40);
        add(0, 1, 32'h0000_0040, 0, 32'h0,           1, 32'h2001_0005,   0, 32'h0);
        add(0, 1, 32'h0000_0042, 0, 32'h0,           1, 32'h2001_0005,   0, 32'h0);
        add(0, 0, 32'h0000_0040, 0, 32'h0,           0, 32'h0,           0, 32'h0);
        // conflict on index 0
        add(0, 1, 32'h0000_0080, 0, 32'hAAAA_0080,   0, 32'h0,           0, 32'h0);
        add(0, 1, 32'h0000_0080, 0, 32'hAAAA_0080,   0, 32'h0,           1, 32'h80);
        add(0, 1, 32'h0000_0080, 0, 32'h0,           1, 32'hAAAA_0080,   0, 32'h0);
        add(0, 1, 32'h0000_0040, 0, 32'h0,           0, 32'h0,           0, 32'h0);
        add(0, 1, 32'h0000_0040, 0, 32'h2001_0005,   0, 32'h0,           1, 32'h40);
        add(0, 1, 32'h0000_0040, 0, 32'h0,           1, 32'h2001_0005,   0, 32'h0);
        // redirect mid-fill to another index; original fill still lands
        add(0, 1, 32'h0000_0100, 1, 32'h0,           0, 32'h0,           0, 32'h0);
        add(0, 1, 32'h0000_0204, 1, 32'h1111_0100,   0, 32'h0,           1, 32'h100);
        add(0, 1, 32'h0000_0204, 0, 32'h1111_0100,   0, 32'h0,           1, 32'h100);
        add(0, 1, 32'h0000_0204, 0, 32'h2222_0204,   0, 32'h0,           0, 32'h0);
        add(0, 1, 32'h0000_0204, 0, 32'h2222_0204,   0, 32'h0,           1, 32'h204);
        add(0, 1, 32'h0000_0100, 0, 32'h0,           1, 32'h1111_0100,   0, 32'h0);
        add(0, 1, 32'h0000_0204, 0, 32'h0,           1, 32'h2222_0204,   0, 32'h0);
        // request dropped during fill
        add(0, 1, 32'h0000_0300, 1, 32'h0,           0, 32'h0,           0, 32'h0);
        add(0, 0, 32'h0000_0300, 0, 32'h3333_0300,   0, 32'h0,           1, 32'h300);
        add(0, 1, 32'h0000_0300, 0, 32'h0,           1, 32'h3333_0300,   0, 32'h0);
        // reset during a completing fill
        add(0, 1, 32'h0000_0040, 0, 32'h0,           0, 32'h0,           0, 32'h0);
        add(1, 1, 32'h0000_0040, 0, 32'hDEAD_BEEF,   0, 32'h0,           1, 32'h40);
        add(1, 1, 32'h0000_0040, 0, 32'hDEAD_BEEF,   0, 32'h0,           0, 32'h0);
        add(0, 1, 32'h0000_0204, 1, 32'h0,           0, 32'h0,           0, 32'h0);
        add(0, 0, 32'h0000_0204, 0, 32'h0,           0, 32'h0,           1, 32'h204);
        add(0, 1, 32'h0000_0040, 0, 32'h0,           0, 32'h0,           0, 32'h0);
        add(0, 1, 32'h0000_0040, 0, 32'h2001_0005,   0, 32'h0,           1, 32'h40);
        add(0, 1, 32'h0000_0040, 0, 32'h0,           1, 32'h2001_0005,   0, 32'h0);

        @(posedge CLK);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ren, vecs[i].addr, vecs[i].wt, vecs[i].ld);
            #4;
            check32("ihit",     i, {31'h0, ihit}, {31'h0, vecs[i].e_hit});
            check32("imemload", i, imemload,      vecs[i].e_load);
            check32("iREN",     i, {31'h0, iREN}, {31'h0, vecs[i].e_ren});
            check32("iaddr",    i, iaddr,         vecs[i].e_iaddr);
            @(posedge CLK);
            #1;
        end

`ifdef ICACHE_STATS_EN
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge CLK); #1;
        check32("hit_count_rst",  0, hit_count,  32'd0);
        check32("miss_count_rst", 0, miss_count, 32'd0);
        drive(0, 1, 32'h400, 0, 32'h4444_0400); @(posedge CLK); #1;
        drive(0, 1, 32'h400, 0, 32'h4444_0400); @(posedge CLK); #1;
        drive(0, 1, 32'h400, 0, 32'h0);         @(posedge CLK); #1;
        drive(0, 1, 32'h404, 0, 32'h5555_0404); @(posedge CLK); #1;
        drive(0, 1, 32'h404, 0, 32'h5555_0404); @(posedge CLK); #1;
        drive(0, 1, 32'h404, 0, 32'h0);         @(posedge CLK); #1;
        drive(0, 1, 32'h400, 0, 32'h0);         @(posedge CLK); #1;
        drive(0, 1, 32'h404, 0, 32'h0);         @(posedge CLK); #1;
        drive(0, 1, 32'h400, 0, 32'h0);         @(posedge CLK); #1;
        drive(0, 0, 32'h400, 0, 32'h0);         @(posedge CLK); #1;
        check32("hit_count",  1, hit_count,  32'd5);
        check32("miss_count", 1, miss_count, 32'd2);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge CLK); #1;
        check32("hit_count_clr",  2, hit_count,  32'd0);
        check32("miss_count_clr", 2, miss_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
